execute_pipe: RTL and testbench

Registered, flow-controlled execute stage for the LEGv8 datapath, sitting between decode/register-read and memory access. It computes the ALU result, zero flag, branch target (PC + imm<<2) and store data for one instruction at a time. It presents them in an output register guarded by a valid/ready handshake, so the memory stage can stall it. Optionally, it executes a multi-cycle iterative multiply, holding off new instructions while busy.

---
 rtl/execute_pipe.sv | 139 +++++++++++++
 tb/tb_execute_pipe.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/execute_pipe.sv
// LEGv8 execute stage: ALU, branch target and store data behind a valid/ready output register.
// Define EXECUTE_MUL_EN to build the iterative shift-add multiplier (AluControl 1000).
module execute_pipe #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         AluSrc,
    input  logic [3:0]   AluControl,
    input  logic [N-1:0] PC_E,
    input  logic [N-1:0] signImm_E,
    input  logic [N-1:0] readData1_E,
    input  logic [N-1:0] readData2_E,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] PCBranch_M,
    output logic [N-1:0] aluResult_M,
    output logic [N-1:0] writeData_M,
    output logic         zero_M
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    logic [N-1:0] op_b, alu_res, pcb;
    logic [N-1:0] ld_res, ld_pcb, ld_wd;
    logic         drain, accept, is_mul, load;

    assign drain  = !out_valid || out_ready;
    assign accept = in_valid && in_ready;

    always_comb begin
        op_b = AluSrc ? signImm_E : readData2_E;
        pcb  = PC_E + (signImm_E << 2);
        case (AluControl)
            OP_AND:  alu_res = readData1_E & op_b;
            OP_OR:   alu_res = readData1_E | op_b;
            OP_ADD:  alu_res = readData1_E + op_b;
            OP_SUB:  alu_res = readData1_E - op_b;
            OP_PASS: alu_res = op_b;
            OP_NOR:  alu_res = ~(readData1_E | op_b);
            default: alu_res = '0;
        endcase
    end

`ifdef EXECUTE_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t        state;
    logic [N-1:0]  acc, mcand, mplier, hold_pcb, hold_wd;
    logic [CW-1:0] cnt;

    assign is_mul   = AluControl == OP_MUL;
    assign in_ready = (state == IDLE) && drain;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            hold_pcb <= '0;
            hold_wd  <= '0;
        end else begin
            case (state)
                IDLE: if (accept && is_mul) begin
                    state    <= MUL;
                    cnt      <= '0;
                    acc      <= '0;
                    mcand    <= readData1_E;
                    mplier   <= op_b;
                    hold_pcb <= pcb;
                    hold_wd  <= readData2_E;
                end
                MUL: begin
                    if (mplier[0])
                        acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(N - 1))
                        state <= DONE;
                end
                DONE: if (drain)
                    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign is_mul   = 1'b0;
    assign in_ready = drain;
`endif

    // Either a fresh single-cycle result or a finished product feeds the output register.
    always_comb begin
        ld_res = alu_res;
        ld_pcb = pcb;
        ld_wd  = readData2_E;
        load   = accept && !is_mul;
`ifdef EXECUTE_MUL_EN
        if (state == DONE) begin
            ld_res = acc;
            ld_pcb = hold_pcb;
            ld_wd  = hold_wd;
            load   = drain;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            PCBranch_M  <= '0;
            aluResult_M <= '0;
            writeData_M <= '0;
            zero_M      <= 1'b1;
        end else if (load) begin
            out_valid   <= 1'b1;
            PCBranch_M  <= ld_pcb;
            aluResult_M <= ld_res;
            writeData_M <= ld_wd;
            zero_M      <= ld_res == '0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_execute_pipe.sv
// Bench for execute_pipe: directed cases plus random traffic against a cycle-level model.
// Follows EXECUTE_MUL_EN the same way as the design.
module tb_execute_pipe;

    localparam int N = 64;
`ifdef EXECUTE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, AluSrc;
    logic [3:0]   AluControl;
    logic [N-1:0] PC_E, signImm_E, readData1_E, readData2_E;
    logic         out_valid, out_ready, zero_M;
    logic [N-1:0] PCBranch_M, aluResult_M, writeData_M;

    int n_chk = 0;
    int n_err = 0;

    // model of the output register and multiplier occupancy
    bit           mov;
    int           mbusy;
    logic [N-1:0] mres, mpcb, mwd, pres, ppcb, pwd;

    always #5 clk = ~clk;

    execute_pipe #(.N(N)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .AluSrc(AluSrc), .AluControl(AluControl),
        .PC_E(PC_E), .signImm_E(signImm_E),
        .readData1_E(readData1_E), .readData2_E(readData2_E),
        .out_valid(out_valid), .out_ready(out_ready),
        .PCBranch_M(PCBranch_M), .aluResult_M(aluResult_M),
        .writeData_M(writeData_M), .zero_M(zero_M)
    );

    task automatic chk(input string tag, input logic [N-1:0] got,
                       input logic [N-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] alu_ref(input logic [3:0] op,
                                             input logic [N-1:0] a,
                                             input logic [N-1:0] b);
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd6:  return a - b;
            4'd7:  return b;
            4'd12: return ~(a | b);
            4'd8:  return MUL_EN ? a * b : '0;
            default: return '0;
        endcase
    endfunction

    // One clock: drive, check before the edge, advance the model at the edge.
    task automatic cycle(input bit iv, input logic [3:0] op, input bit src,
                         input logic [N-1:0] pc, input logic [N-1:0] imm,
                         input logic [N-1:0] a, input logic [N-1:0] b,
                         input bit ordy, input bit rst);
        bit           rdy_exp, ld;
        logic [N-1:0] bv;
        in_valid    = iv;
        AluControl  = op;
        AluSrc      = src;
        PC_E        = pc;
        signImm_E   = imm;
        readData1_E = a;
        readData2_E = b;
        out_ready   = ordy;
        reset       = rst;
        rdy_exp     = (mbusy == 0) && (!mov || ordy);
        @(negedge clk);
        chk("in_ready", N'(in_ready), N'(rdy_exp));
        chk("out_valid", N'(out_valid), N'(mov));
        chk("aluResult", aluResult_M, mres);
        chk("PCBranch", PCBranch_M, mpcb);
        chk("writeData", writeData_M, mwd);
        chk("zero", N'(zero_M), N'(mres == '0));
        @(posedge clk);
        bv = src ? imm : b;
        ld = 1'b0;
        if (rst) begin
            mov = 0; mbusy = 0; mres = '0; mpcb = '0; mwd = '0;
        end else begin
            if (mbusy > 1) begin
                mbusy--;
            end else if (mbusy == 1) begin
                if (!mov || ordy) begin
                    ld = 1'b1; mbusy = 0;
                    mres = pres; mpcb = ppcb; mwd = pwd;
                end
            end else if (iv && rdy_exp) begin
                if (MUL_EN && op == 4'd8) begin
                    mbusy = N + 1;
                    pres = a * bv; ppcb = pc + (imm << 2); pwd = b;
                end else begin
                    ld = 1'b1;
                    mres = alu_ref(op, a, bv); mpcb = pc + (imm << 2); mwd = b;
                end
            end
            if (ld) mov = 1'b1;
            else if (ordy) mov = 1'b0;
        end
        #1;
    endtask

    task automatic idle(input bit ordy);
        cycle(0, 4'd0, 0, '0, '0, '0, '0, ordy, 0);
    endtask

    initial begin
        logic [N-1:0] a, b, imm;
        logic [3:0]   op;
        mov = 0; mbusy = 0; mres = '0; mpcb = '0; mwd = '0;
        pres = '0; ppcb = '0; pwd = '0;
        #1;
        cycle(0, 4'd0, 0, '0, '0, '0, '0, 1, 1);
        cycle(0, 4'd0, 0, '0, '0, '0, '0, 1, 1);
        chk("rst_zero", N'(zero_M), 1);
        chk("rst_ready", N'(in_ready), 1);

        cycle(1, 4'd2, 0, 'h100, 3, 5, 7, 1, 0);
        chk("add_res", aluResult_M, 12);
        chk("add_pcb", PCBranch_M, 'h10C);
        chk("add_wd", writeData_M, 7);
        chk("add_zero", N'(zero_M), 0);

        cycle(1, 4'd6, 1, '0, 'h1234, 'h1234, 'h55, 1, 0);
        chk("sub_res", aluResult_M, 0);
        chk("sub_zero", N'(zero_M), 1);
        cycle(1, 4'd12, 0, '0, '0, '0, '0, 1, 0);
        chk("nor_res", aluResult_M, '1);
        idle(1);

        cycle(1, 4'd0, 0, '0, '0, 'hF0F0, 'h0FF0, 0, 0);
        cycle(1, 4'd1, 0, '0, '0, 'hF000, 'h000F, 0, 0);
        chk("bp_hold", aluResult_M, 'h00F0);
        chk("bp_ready", N'(in_ready), 0);
        cycle(1, 4'd1, 0, '0, '0, 'hF000, 'h000F, 0, 0);
        cycle(1, 4'd1, 0, '0, '0, 'hF000, 'h000F, 1, 0);
        chk("bp_or", aluResult_M, 'hF00F);
        idle(1);
        chk("bp_drain", N'(out_valid), 0);

        for (int i = 0; i < 8; i++) begin
            cycle(1, 4'd2, 0, '0, '0, N'(i), 100, 1, 0);
            chk("stream", aluResult_M, N'(100 + i));
        end
        idle(1);

        cycle(1, 4'd8, 1, '0, 3, '1, 9, 1, 0);
        for (int i = 0; i < N + 1; i++)
            cycle(1, 4'd2, 0, '0, '0, 1, 1, 1, 0);
        if (MUL_EN) begin
            chk("mul_res", aluResult_M, 64'hFFFF_FFFF_FFFF_FFFD);
            chk("mul_pcb", PCBranch_M, 12);
        end
        idle(1);

        cycle(1, 4'd8, 0, '0, '0, 6, 7, 1, 0);
        if (!MUL_EN) begin
            chk("mul_off_res", aluResult_M, 0);
            chk("mul_off_zero", N'(zero_M), 1);
        end
        for (int i = 0; i < 10; i++) idle(1);
        cycle(0, 4'd0, 0, '0, '0, '0, '0, 1, 1);
        chk("rst_mid_ov", N'(out_valid), 0);
        chk("rst_mid_rdy", N'(in_ready), 1);
        for (int i = 0; i < 3; i++) idle(1);

        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0: op = 4'($urandom_range(0, 15));
                1: op = 4'd0;
                2: op = 4'd1;
                3: op = 4'd6;
                4: op = 4'd7;
                5: op = 4'd12;
                6: op = ($urandom_range(0, 3) == 0) ? 4'd8 : 4'd2;
                default: op = 4'd2;
            endcase
            a   = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : N'($urandom_range(0, 20));
            b   = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
            imm = ($urandom_range(0, 1) == 1) ? a : N'($urandom);
            cycle(bit'($urandom_range(0, 3) != 0), op, bit'($urandom_range(0, 1)),
                  {$urandom, $urandom}, imm, a, b,
                  bit'($urandom_range(0, 3) != 0), $urandom_range(0, 199) == 0);
        end
        for (int i = 0; i < N + 4; i++) idle(1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
